// File: rtl/dd_queue_ctx_pipe_pkg.sv
// Shared DD widths and thresholds, plus the per-flow context record.
// Imported by the queue-context pipeline and its helpers.
package dd_queue_ctx_pipe_pkg;

    localparam int FLOW_ID_W              = 4;
    localparam int PKT_QUEUE_IND_W        = 8;
    localparam int FLAG_W                 = 1;
    localparam int PKT_QUEUE_START_THRESH = 4;
    localparam int PKT_QUEUE_STOP_THRESH  = 8;

    typedef logic [PKT_QUEUE_IND_W-1:0] qsize_t;
    typedef logic [FLAG_W-1:0]          flag_t;

    typedef struct packed {
        qsize_t size;
        flag_t  bp;
    } flow_ctx_t;

    typedef enum logic {
        EVT_DEQ = 1'b0,
        EVT_ENQ = 1'b1
    } evt_kind_t;

    function automatic logic is_full(input qsize_t s);
        return &s;
    endfunction

endpackage

// File: rtl/dd_act_fifo.sv
// First-word-fall-through activation FIFO with occupancy count.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module dd_act_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign valid    = count != '0;
    assign full     = count == (PTR_W+1)'(DEPTH);
    assign do_pop   = pop & valid;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
        end
    end

    // storage carries no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dd_dequeue_prop.sv
// Dequeue event processor: decrements occupancy and releases back-pressure
// once the queue drains below the restart threshold.
module dd_dequeue_prop
    import dd_queue_ctx_pipe_pkg::*;
(
    input  logic [PKT_QUEUE_IND_W-1:0] size,
    input  logic [FLAG_W-1:0]          bp,
    output logic [PKT_QUEUE_IND_W-1:0] size_new,
    output logic [FLAG_W-1:0]          bp_new,
    output logic                       activated
);

    logic below_start;

    assign size_new    = size - PKT_QUEUE_IND_W'(1);
    assign below_start = size_new < PKT_QUEUE_IND_W'(PKT_QUEUE_START_THRESH);
    assign bp_new      = bp & ~{FLAG_W{below_start}};
    assign activated   = (|bp) & below_start;

endmodule

// File: rtl/dd_queue_ctx_pipe.sv
// Two-stage per-flow queue context pipeline: S1 reads the context, S2 updates
// and writes it back, pushing released flows to the scheduler FIFO.
module dd_queue_ctx_pipe
    import dd_queue_ctx_pipe_pkg::*;
#(
    parameter int FLOW_NUM       = 16,
    parameter int ACT_FIFO_DEPTH = 4,
    parameter int STOP_THRESH    = PKT_QUEUE_STOP_THRESH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       evt_valid,
    input  logic                       evt_is_enq,
    input  logic [FLOW_ID_W-1:0]       evt_fid,
    output logic                       evt_ready,
    output logic                       act_valid,
    output logic [FLOW_ID_W-1:0]       act_fid,
    input  logic                       act_ready,
    output logic                       underflow_err,
    output logic                       overflow_err,
    input  logic [FLOW_ID_W-1:0]       obs_fid,
    output logic [PKT_QUEUE_IND_W-1:0] obs_size,
    output logic [FLAG_W-1:0]          obs_bp
);

    localparam int     CNT_W  = $clog2(ACT_FIFO_DEPTH) + 1;
    localparam qsize_t STOP_Q = qsize_t'(STOP_THRESH);

    flow_ctx_t ctx_q [FLOW_NUM];

    logic                 evt_accept;
    logic                 s1_valid;
    evt_kind_t            s1_kind;
    logic [FLOW_ID_W-1:0] s1_fid;
    flow_ctx_t            s1_ctx;
    logic                 s2_valid;
    evt_kind_t            s2_kind;
    logic [FLOW_ID_W-1:0] s2_fid;
    flow_ctx_t            s2_ctx;

    flow_ctx_t            s2_ctx_new;
    logic                 s2_push;
    logic                 s2_uf;
    logic                 s2_of;
    qsize_t               enq_size;
    qsize_t               deq_size;
    flag_t                deq_bp;
    logic                 deq_act;

    logic [CNT_W-1:0]     fifo_count;
    logic [CNT_W:0]       occupancy;
    logic                 fwd_to_s1;
    logic                 fwd_to_s2;

    // every in-flight event reserves a FIFO slot, so a push can never be dropped
    assign occupancy  = {1'b0, fifo_count} + (CNT_W+1)'(s1_valid) + (CNT_W+1)'(s2_valid);
    assign evt_ready  = occupancy < (CNT_W+1)'(ACT_FIFO_DEPTH);
    assign evt_accept = evt_valid & evt_ready;

    assign fwd_to_s1 = s2_valid && (s2_fid == evt_fid);
    assign fwd_to_s2 = s2_valid && (s2_fid == s1_fid);

    dd_dequeue_prop u_dequeue_prop (
        .size      (s2_ctx.size),
        .bp        (s2_ctx.bp),
        .size_new  (deq_size),
        .bp_new    (deq_bp),
        .activated (deq_act)
    );

    assign enq_size = s2_ctx.size + qsize_t'(1);

    always_comb begin
        s2_ctx_new = s2_ctx;
        s2_push    = 1'b0;
        s2_uf      = 1'b0;
        s2_of      = 1'b0;
        if (s2_valid) begin
            if (s2_kind == EVT_ENQ) begin
                if (is_full(s2_ctx.size)) begin
                    s2_of = 1'b1;
                end else begin
                    s2_ctx_new.size = enq_size;
                    s2_ctx_new.bp   = s2_ctx.bp | {FLAG_W{enq_size >= STOP_Q}};
                end
            end else if (s2_ctx.size == '0) begin
                s2_uf = 1'b1;
            end else begin
                s2_ctx_new.size = deq_size;
                s2_ctx_new.bp   = deq_bp;
                s2_push         = deq_act;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FLOW_NUM; i++) ctx_q[i] <= '0;
        end else if (s2_valid) begin
            ctx_q[s2_fid] <= s2_ctx_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            underflow_err <= 1'b0;
            overflow_err  <= 1'b0;
        end else begin
            s1_valid      <= evt_accept;
            s2_valid      <= s1_valid;
            underflow_err <= s2_uf;
            overflow_err  <= s2_of;
        end
    end

    // both stages pick up the S2 result for the same flow so back-to-back events serialize
    always_ff @(posedge clk) begin
        if (evt_accept) begin
            s1_kind <= evt_kind_t'(evt_is_enq);
            s1_fid  <= evt_fid;
            s1_ctx  <= fwd_to_s1 ? s2_ctx_new : ctx_q[evt_fid];
        end
        if (s1_valid) begin
            s2_kind <= s1_kind;
            s2_fid  <= s1_fid;
            s2_ctx  <= fwd_to_s2 ? s2_ctx_new : s1_ctx;
        end
    end

    dd_act_fifo #(
        .WIDTH (FLOW_ID_W),
        .DEPTH (ACT_FIFO_DEPTH)
    ) u_act_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s2_push),
        .push_data (s2_fid),
        .pop       (act_ready),
        .pop_data  (act_fid),
        .valid     (act_valid),
        .count     (fifo_count)
    );

    assign obs_size = ctx_q[obs_fid].size;
    assign obs_bp   = ctx_q[obs_fid].bp;

endmodule

// File: tb/tb_dd_queue_ctx_pipe.sv
// Self-checking bench for dd_queue_ctx_pipe: events are applied to a serialized
// per-flow reference model at acceptance time and outcomes compared afterwards.
module tb_dd_queue_ctx_pipe;

    localparam int NFLOW = 16;
    localparam int START = 4;
    localparam int STOP  = 8;
    localparam int QMAX  = 255;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       evt_valid;
    logic       evt_is_enq;
    logic [3:0] evt_fid;
    logic       evt_ready;
    logic       act_valid;
    logic [3:0] act_fid;
    logic       act_ready;
    logic       underflow_err;
    logic       overflow_err;
    logic [3:0] obs_fid;
    logic [7:0] obs_size;
    logic [0:0] obs_bp;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int m_size [NFLOW];
    bit m_bp   [NFLOW];
    int exp_act[$];
    int exp_uf [$];
    int exp_of [$];
    int got_act[$];
    int got_act_cyc[$];
    int got_uf [$];
    int got_of [$];

    dd_queue_ctx_pipe dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .evt_valid     (evt_valid),
        .evt_is_enq    (evt_is_enq),
        .evt_fid       (evt_fid),
        .evt_ready     (evt_ready),
        .act_valid     (act_valid),
        .act_fid       (act_fid),
        .act_ready     (act_ready),
        .underflow_err (underflow_err),
        .overflow_err  (overflow_err),
        .obs_fid       (obs_fid),
        .obs_size      (obs_size),
        .obs_bp        (obs_bp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (act_valid && act_ready) begin
            got_act.push_back(int'(act_fid));
            got_act_cyc.push_back(cyc);
        end
        if (underflow_err) got_uf.push_back(cyc);
        if (overflow_err)  got_of.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 2ms", $time);
        $fatal(1, "watchdog");
    end

    // serialized golden behaviour; outcomes land two edges after acceptance
    function automatic void model_apply(input bit enq, input int fid, input int acc);
        if (enq) begin
            if (m_size[fid] == QMAX) exp_of.push_back(acc + 2);
            else begin
                m_size[fid] = m_size[fid] + 1;
                if (m_size[fid] >= STOP) m_bp[fid] = 1'b1;
            end
        end else begin
            if (m_size[fid] == 0) exp_uf.push_back(acc + 2);
            else begin
                m_size[fid] = m_size[fid] - 1;
                if (m_bp[fid] && m_size[fid] < START) begin
                    m_bp[fid] = 1'b0;
                    exp_act.push_back(fid);
                end
            end
        end
    endfunction

    function automatic void model_reset();
        for (int f = 0; f < NFLOW; f++) begin
            m_size[f] = 0;
            m_bp[f]   = 1'b0;
        end
        exp_act.delete(); exp_uf.delete(); exp_of.delete();
        got_act.delete(); got_act_cyc.delete(); got_uf.delete(); got_of.delete();
    endfunction

    function automatic void clear_queues();
        exp_act.delete(); exp_uf.delete(); exp_of.delete();
        got_act.delete(); got_act_cyc.delete(); got_uf.delete(); got_of.delete();
    endfunction

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // called 1 time unit after a rising edge; returns 1 time unit after the accepting edge
    task automatic send(input bit enq, input int fid, output int acc);
        int guard = 0;
        acc = cyc;
        while (!evt_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!evt_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout fid=%0d: evt_ready got 0 for 200 cycles, required 1", fid);
            return;
        end
        evt_valid  = 1'b1;
        evt_is_enq = enq;
        evt_fid    = 4'(fid);
        @(posedge clk); #1;
        evt_valid  = 1'b0;
        acc = cyc;
        model_apply(enq, fid, acc);
    endtask

    task automatic test_reset();
        for (int f = 0; f < NFLOW; f++) begin
            obs_fid = 4'(f); #1;
            n_checks++;
            if (obs_size !== 8'd0 || obs_bp !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctx fid=%0d got size=%0d bp=%0d required 0/0", f, obs_size, obs_bp);
            end
        end
        n_checks++;
        if (act_valid !== 1'b0) begin n_fail++; $display("FAIL reset_act_valid got %b required 0", act_valid); end
        n_checks++;
        if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL reset_evt_ready got %b required 1", evt_ready); end
        n_checks++;
        if (underflow_err !== 1'b0 || overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err got uf=%b of=%b required 0/0", underflow_err, overflow_err);
        end
        drain(1);
    endtask

    task automatic test_threshold();
        int acc;
        clear_queues();
        act_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(1'b1, 3, acc);
        drain(4);
        obs_fid = 4'd3; #1;
        n_checks++;
        if (obs_size !== 8'd7 || obs_bp !== 1'b0) begin
            n_fail++; $display("FAIL thresh_enq7 got size=%0d bp=%0d required 7/0", obs_size, obs_bp);
        end
        drain(1);
        send(1'b1, 3, acc);
        drain(4);
        n_checks++;
        if (obs_size !== 8'd8 || obs_bp !== 1'b1) begin
            n_fail++; $display("FAIL thresh_enq8 got size=%0d bp=%0d required 8/1", obs_size, obs_bp);
        end
        send(1'b1, 3, acc);
        send(1'b1, 3, acc);
        drain(4);
        n_checks++;
        if (obs_size !== 8'd10 || obs_bp !== 1'b1) begin
            n_fail++; $display("FAIL thresh_enq10 got size=%0d bp=%0d required 10/1", obs_size, obs_bp);
        end
        for (int i = 0; i < 6; i++) send(1'b0, 3, acc);
        drain(6);
        n_checks++;
        if (got_act.size() != 0) begin
            n_fail++; $display("FAIL thresh_no_act_at4 got %0d activations required 0", got_act.size());
        end
        n_checks++;
        if (obs_size !== 8'd4 || obs_bp !== 1'b1) begin
            n_fail++; $display("FAIL thresh_deq6 got size=%0d bp=%0d required 4/1", obs_size, obs_bp);
        end
        send(1'b0, 3, acc);
        drain(6);
        n_checks++;
        if (got_act.size() != 1 || got_act[0] != 3) begin
            n_fail++; $display("FAIL thresh_act got count=%0d fid=%0d required 1 x fid 3", got_act.size(), got_act[0]);
        end
        n_checks++;
        if (got_act_cyc[0] != acc + 2) begin
            n_fail++; $display("FAIL thresh_act_latency got cycle %0d required %0d", got_act_cyc[0], acc + 2);
        end
        n_checks++;
        if (obs_size !== 8'd3 || obs_bp !== 1'b0) begin
            n_fail++; $display("FAIL thresh_release got size=%0d bp=%0d required 3/0", obs_size, obs_bp);
        end
        n_checks++;
        if (exp_act.size() != 1) begin
            n_fail++; $display("FAIL thresh_model_act got model count %0d required 1", exp_act.size());
        end
    endtask

    task automatic test_underflow();
        int acc;
        clear_queues();
        send(1'b0, 5, acc);
        drain(6);
        n_checks++;
        if (got_uf.size() != 1 || got_uf[0] != acc + 2) begin
            n_fail++; $display("FAIL underflow_pulse got %0d pulses first at %0d required 1 at %0d", got_uf.size(), got_uf[0], acc + 2);
        end
        n_checks++;
        if (got_uf.size() != exp_uf.size()) begin
            n_fail++; $display("FAIL underflow_model got %0d required %0d", got_uf.size(), exp_uf.size());
        end
        obs_fid = 4'd5; #1;
        n_checks++;
        if (obs_size !== 8'd0 || obs_bp !== 1'b0) begin
            n_fail++; $display("FAIL underflow_ctx got size=%0d bp=%0d required 0/0", obs_size, obs_bp);
        end
        n_checks++;
        if (got_act.size() != 0 || got_of.size() != 0) begin
            n_fail++; $display("FAIL underflow_side got act=%0d of=%0d required 0/0", got_act.size(), got_of.size());
        end
        drain(1);
    endtask

    task automatic test_back_to_back();
        int acc;
        int fid;
        clear_queues();
        act_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(1'b1, 2, acc);
        send(1'b0, 2, acc);
        for (int i = 0; i < 24; i++) send((i % 2) == 0, 2, acc);
        for (int i = 0; i < 120; i++) begin
            fid = ($urandom % 4 == 0) ? int'($urandom_range(0, NFLOW - 1)) : 2;
            act_ready = ($urandom % 3 != 0) || !evt_ready;
            send(bit'($urandom % 2), fid, acc);
            if ($urandom % 4 == 0) drain(1 + ($urandom % 2));
        end
        act_ready = 1'b1;
        drain(10);
        n_checks++;
        if (got_act.size() != exp_act.size()) begin
            n_fail++; $display("FAIL b2b_act_count got %0d required %0d", got_act.size(), exp_act.size());
        end
        foreach (exp_act[i]) begin
            n_checks++;
            if (got_act[i] != exp_act[i]) begin
                n_fail++; $display("FAIL b2b_act_order idx=%0d got fid %0d required %0d", i, got_act[i], exp_act[i]);
            end
        end
        n_checks++;
        if (got_uf.size() != exp_uf.size()) begin
            n_fail++; $display("FAIL b2b_uf_count got %0d required %0d", got_uf.size(), exp_uf.size());
        end
        foreach (exp_uf[i]) begin
            n_checks++;
            if (got_uf[i] != exp_uf[i]) begin
                n_fail++; $display("FAIL b2b_uf_cycle idx=%0d got %0d required %0d", i, got_uf[i], exp_uf[i]);
            end
        end
        for (int f = 0; f < NFLOW; f++) begin
            obs_fid = 4'(f); #1;
            n_checks++;
            if (int'(obs_size) != m_size[f] || obs_bp !== m_bp[f]) begin
                n_fail++;
                $display("FAIL b2b_ctx fid=%0d got size=%0d bp=%0d required %0d/%0d", f, obs_size, obs_bp, m_size[f], m_bp[f]);
            end
        end
        drain(1);
    endtask

    task automatic prep_released_edge(input int f);
        int acc;
        while (m_size[f] < STOP) send(1'b1, f, acc);
        while (m_size[f] > START) send(1'b0, f, acc);
    endtask

    task automatic test_backpressure();
        int acc;
        act_ready = 1'b1;
        for (int f = 1; f <= 4; f++) prep_released_edge(f);
        drain(6);
        clear_queues();
        act_ready = 1'b0;
        for (int f = 1; f <= 4; f++) send(1'b0, f, acc);
        n_checks++;
        if (evt_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop got %b required 0", evt_ready); end
        drain(3);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (act_valid !== 1'b1 || act_fid !== 4'd1 || evt_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d got valid=%b fid=%0d ready=%b required 1/1/0", i, act_valid, act_fid, evt_ready);
            end
            drain(1);
        end
        act_ready = 1'b1;
        drain(8);
        n_checks++;
        if (got_act.size() != 4 || exp_act.size() != 4) begin
            n_fail++; $display("FAIL bp_act_count got %0d required 4 (model %0d)", got_act.size(), exp_act.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_act[i] != i + 1) begin
                n_fail++; $display("FAIL bp_act_order idx=%0d got fid %0d required %0d", i, got_act[i], i + 1);
            end
        end
        n_checks++;
        if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_restore got %b required 1", evt_ready); end
    endtask

    task automatic test_overflow();
        int acc;
        clear_queues();
        while (m_size[0] < QMAX) send(1'b1, 0, acc);
        drain(4);
        obs_fid = 4'd0; #1;
        n_checks++;
        if (obs_size !== 8'd255 || obs_bp !== 1'b1) begin
            n_fail++; $display("FAIL ovf_fill got size=%0d bp=%0d required 255/1", obs_size, obs_bp);
        end
        n_checks++;
        if (got_of.size() != 0) begin n_fail++; $display("FAIL ovf_early got %0d pulses required 0", got_of.size()); end
        drain(1);
        send(1'b1, 0, acc);
        drain(5);
        n_checks++;
        if (got_of.size() != 1 || got_of[0] != acc + 2 || exp_of.size() != 1) begin
            n_fail++; $display("FAIL ovf_pulse got %0d pulses first at %0d required 1 at %0d", got_of.size(), got_of[0], acc + 2);
        end
        n_checks++;
        if (obs_size !== 8'd255) begin n_fail++; $display("FAIL ovf_hold got size=%0d required 255", obs_size); end
        drain(1);
    endtask

    task automatic test_reset_midop();
        int acc;
        act_ready = 1'b1;
        prep_released_edge(6);
        prep_released_edge(7);
        drain(6);
        clear_queues();
        act_ready = 1'b0;
        send(1'b0, 6, acc);
        send(1'b0, 7, acc);
        send(1'b1, 8, acc);
        send(1'b1, 9, acc);
        rst_n = 1'b0;
        drain(1);
        rst_n = 1'b1;
        model_reset();
        n_checks++;
        if (act_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_act_valid got %b required 0", act_valid); end
        n_checks++;
        if (evt_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_evt_ready got %b required 1", evt_ready); end
        for (int f = 0; f < NFLOW; f++) begin
            obs_fid = 4'(f); #1;
            n_checks++;
            if (obs_size !== 8'd0 || obs_bp !== 1'b0) begin
                n_fail++; $display("FAIL midrst_ctx fid=%0d got size=%0d bp=%0d required 0/0", f, obs_size, obs_bp);
            end
        end
        act_ready = 1'b1;
        drain(6);
        n_checks++;
        if (got_act.size() != 0 || got_uf.size() != 0 || got_of.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_stale got act=%0d uf=%0d of=%0d required 0/0/0", got_act.size(), got_uf.size(), got_of.size());
        end
        obs_fid = 4'd9; #1;
        n_checks++;
        if (obs_size !== 8'd0) begin n_fail++; $display("FAIL midrst_inflight got size=%0d required 0", obs_size); end
        drain(1);
        send(1'b1, 8, acc);
        drain(4);
        obs_fid = 4'd8; #1;
        n_checks++;
        if (int'(obs_size) != m_size[8]) begin
            n_fail++; $display("FAIL midrst_resume got size=%0d required %0d", obs_size, m_size[8]);
        end
        drain(1);
    endtask

    initial begin
        rst_n      = 1'b0;
        evt_valid  = 1'b0;
        evt_is_enq = 1'b0;
        evt_fid    = 4'd0;
        act_ready  = 1'b1;
        obs_fid    = 4'd0;
        model_reset();
        drain(3);
        rst_n = 1'b1;
        drain(1);
        test_reset();
        test_threshold();
        test_underflow();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
